// File: rtl/maxnet_pkg.sv
// Shared types, constants and float helpers for the MaxNet winner-take-all block.
// Latency: n/a (package only).
// Backpressure: n/a.
// Contents: FP field widths, FSM state enum, FP_ZERO / FP_MAXFIN constants,
//           fp_clamp (input sanitising) and fp_scale (multiply by 2^-k).
package maxnet_pkg;

  localparam int FP_W  = 32;
  localparam int EXP_W = 8;
  localparam int MAN_W = 23;

  localparam logic [FP_W-1:0]  FP_ZERO   = 32'h0000_0000;
  localparam logic [FP_W-1:0]  FP_MAXFIN = 32'h7F7F_FFFF;
  localparam logic [EXP_W-1:0] EXP_ALL1  = 8'hFF;

  typedef enum logic [2:0] {
    IDLE,
    LOAD,
    SUM,
    UPD,
    CHECK,
    DONE
  } state_t;

  // Sanitise an input into the non-negative normal/zero domain the adder handles.
  function automatic logic [FP_W-1:0] fp_clamp(input logic [FP_W-1:0] x);
    logic [FP_W-1:0] r;
    if (x[FP_W-1])                           r = FP_ZERO;
    else if (x[FP_W-2 -: EXP_W] == '0)       r = FP_ZERO;
    else if (x[FP_W-2 -: EXP_W] == EXP_ALL1) r = FP_MAXFIN;
    else                                     r = x;
    return r;
  endfunction

  // Multiply by 2^-k through the exponent field; anything that would land
  // at exponent 0 or below is flushed to +0.
  function automatic logic [FP_W-1:0] fp_scale(input logic [FP_W-1:0] x, input int k);
    logic [EXP_W-1:0] e;
    logic [FP_W-1:0]  r;
    e = x[FP_W-2 -: EXP_W];
    if (int'(e) <= k) r = FP_ZERO;
    else              r = {x[FP_W-1], e - EXP_W'(k), x[MAN_W-1:0]};
    return r;
  endfunction

endpackage

// File: rtl/fp_addsub.sv
// Non-negative IEEE-754 single add/subtract with truncation and ReLU flag.
// Latency: combinational.
// Backpressure: none (pure function of its inputs).
// Ports: a, b  - operands (non-negative normals or +0)
//        sub   - 0: a+b, 1: a-b
//        res   - result, +0 on zero/underflow/negative, FP_MAXFIN on overflow
//        neg   - high when a-b would have been negative (result forced to +0)
module fp_addsub
  import maxnet_pkg::*;
(
  input  logic [FP_W-1:0] a,
  input  logic [FP_W-1:0] b,
  input  logic            sub,
  output logic [FP_W-1:0] res,
  output logic            neg
);

  logic             a_ge_b;
  logic [EXP_W-1:0] e_big;
  logic [EXP_W-1:0] e_sml;
  logic [EXP_W-1:0] d;
  logic [MAN_W:0]   m_big;
  logic [MAN_W:0]   m_sml;
  logic [MAN_W:0]   m_sh;
  logic [MAN_W+1:0] sum;
  logic [MAN_W:0]   diff;
  logic [MAN_W-1:0] norm;
  int               lz;

  always_comb begin
    res  = FP_ZERO;
    neg  = 1'b0;
    norm = '0;
    // Both operands are non-negative, so raw bit order equals numeric order.
    a_ge_b = (a >= b);
    e_big  = a_ge_b ? a[FP_W-2 -: EXP_W] : b[FP_W-2 -: EXP_W];
    e_sml  = a_ge_b ? b[FP_W-2 -: EXP_W] : a[FP_W-2 -: EXP_W];
    m_big  = a_ge_b ? {|a[FP_W-2 -: EXP_W], a[MAN_W-1:0]}
                    : {|b[FP_W-2 -: EXP_W], b[MAN_W-1:0]};
    m_sml  = a_ge_b ? {|b[FP_W-2 -: EXP_W], b[MAN_W-1:0]}
                    : {|a[FP_W-2 -: EXP_W], a[MAN_W-1:0]};
    d      = e_big - e_sml;
    m_sh   = (d > 8'd23) ? '0 : (m_sml >> d);
    sum    = {1'b0, m_big} + {1'b0, m_sh};
    diff   = m_big - m_sh;

    // Leading-zero count of diff: the highest set bit wins.
    lz = MAN_W + 1;
    for (int i = 0; i <= MAN_W; i++) begin
      if (diff[i]) lz = MAN_W - i;
    end

    if (sub && !a_ge_b) begin
      neg = 1'b1;
      res = FP_ZERO;
    end else if (m_big == '0) begin
      res = FP_ZERO;
    end else if (!sub) begin
      if (sum[MAN_W+1]) begin
        if (e_big >= 8'd254) res = FP_MAXFIN;
        else                 res = {1'b0, e_big + 8'd1, sum[MAN_W:1]};
      end else begin
        res = {1'b0, e_big, sum[MAN_W-1:0]};
      end
    end else begin
      if (diff == '0) begin
        res = FP_ZERO;
      end else if (lz >= int'(e_big)) begin
        res = FP_ZERO;
      end else begin
        norm = MAN_W'(diff << lz);
        res  = {1'b0, e_big - EXP_W'(lz), norm};
      end
    end
  end

endmodule

// File: rtl/maxnet_top.sv
// Four-neuron MaxNet: iterates lateral inhibition, then outputs the winning raw input.
// Latency: 1 (LOAD) + 12 per iteration + 1 (DONE) cycles from the start sample to done.
// Backpressure: none; start is ignored while a run is in progress.
// Ports: clk, rst (sync, active-high), start (level, sampled in IDLE),
//        x1..x4 (IEEE-754 single inputs), out (winner's original bits, held),
//        done (one-cycle pulse with a new out).
// Build option: define MAXNET_TIMEOUT_EN to cap the run at MAX_ITER iterations,
//        after which the largest activation (lowest index on ties) wins.
module maxnet_top
  import maxnet_pkg::*;
#(
  parameter int EPS_SHIFT = 3,
  parameter int MAX_ITER  = 255
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            start,
  input  logic [FP_W-1:0] x1,
  input  logic [FP_W-1:0] x2,
  input  logic [FP_W-1:0] x3,
  input  logic [FP_W-1:0] x4,
  output logic [FP_W-1:0] out,
  output logic            done
);

  // epsilon = 2^-EPS_SHIFT must stay below 1/3; the counter is 8 bits wide.
  if (EPS_SHIFT < 2 || EPS_SHIFT > 126 || MAX_ITER < 1 || MAX_ITER > 255) begin : g_bad_cfg
    $error("maxnet_top: EPS_SHIFT must be 2..126 and MAX_ITER 1..255");
  end

  state_t          state, state_nxt;
  logic [2:0]      cnt;
  logic [FP_W-1:0] act  [4];
  logic [FP_W-1:0] orig [4];
  logic [FP_W-1:0] s;
  logic [FP_W-1:0] t;
  logic [3:0]      prev_nz;
  logic            chg;
  logic [1:0]      win, win_nxt;

  logic [FP_W-1:0] op_a, op_b, add_res;
  logic            op_sub, add_neg;
  logic [1:0]      ui;
  logic [3:0]      nz;
  logic [2:0]      nz_cnt;
  logic [1:0]      first_nz, first_prev, argmax;
  logic            timeout_hit;

  assign ui = cnt[2:1];

  fp_addsub u_addsub (
    .a   (op_a),
    .b   (op_b),
    .sub (op_sub),
    .res (add_res),
    .neg (add_neg)
  );

  // One adder serves both phases: SUM accumulates S, UPD computes
  // T = S - a[i] (even step) then a[i] - T*eps (odd step).
  always_comb begin
    op_a   = s;
    op_b   = act[ui];
    op_sub = 1'b0;
    case (state)
      SUM: begin
        case (cnt)
          3'd0:    begin op_a = act[0]; op_b = act[1]; end
          3'd1:    op_b = act[2];
          default: op_b = act[3];
        endcase
      end
      UPD: begin
        op_sub = 1'b1;
        if (cnt[0]) begin
          op_a = act[ui];
          op_b = fp_scale(t, EPS_SHIFT);
        end
      end
      default: ;
    endcase
  end

  always_comb begin
    nz         = '0;
    nz_cnt     = '0;
    first_nz   = '0;
    first_prev = '0;
    argmax     = '0;
    for (int i = 0; i < 4; i++) begin
      nz[i]  = |act[i];
      nz_cnt = nz_cnt + {2'b00, nz[i]};
    end
    for (int i = 3; i >= 0; i--) begin
      if (nz[i])      first_nz   = 2'(i);
      if (prev_nz[i]) first_prev = 2'(i);
    end
    // Activations are non-negative, so unsigned bit compare orders them;
    // strict '>' keeps the lowest index on ties.
    for (int i = 1; i < 4; i++) begin
      if (act[i] > act[argmax]) argmax = 2'(i);
    end
  end

`ifdef MAXNET_TIMEOUT_EN
  logic [7:0] iter;

  always_ff @(posedge clk) begin
    if (rst)                 iter <= '0;
    else if (state == LOAD)  iter <= '0;
    else if (state == CHECK) iter <= iter + 8'd1;
  end

  assign timeout_hit = (32'(iter) + 32'd1) >= MAX_ITER;
`else
  assign timeout_hit = 1'b0;
`endif

  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    win_nxt   = win;
    case (state)
      IDLE:  if (start) state_nxt = LOAD;
      LOAD:  state_nxt = SUM;
      SUM:   if (cnt == 3'd2) state_nxt = UPD;
      UPD:   if (cnt == 3'd7) state_nxt = CHECK;
      CHECK: begin
        state_nxt = DONE;
        if (nz_cnt >= 3'd2) begin
          if (timeout_hit) begin
            win_nxt = argmax;
          end else if (!chg) begin
            // Every live neuron's inhibition term has flushed to zero, so the
            // network is frozen; resolve it like a simultaneous extinction.
            win_nxt = first_nz;
          end else begin
            state_nxt = SUM;
          end
        end else if (nz_cnt == 3'd1) begin
          win_nxt = first_nz;
        end else begin
          // All died in the last pass: lowest survivor before it, else neuron 1.
          win_nxt = first_prev;
        end
      end
      DONE:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt     <= '0;
      s       <= FP_ZERO;
      t       <= FP_ZERO;
      prev_nz <= '0;
      chg     <= 1'b0;
      win     <= '0;
      out     <= FP_ZERO;
      done    <= 1'b0;
      for (int i = 0; i < 4; i++) begin
        act[i]  <= FP_ZERO;
        orig[i] <= FP_ZERO;
      end
    end else begin
      win  <= win_nxt;
      done <= 1'b0;
      case (state)
        LOAD: begin
          orig[0] <= x1;
          orig[1] <= x2;
          orig[2] <= x3;
          orig[3] <= x4;
          act[0]  <= fp_clamp(x1);
          act[1]  <= fp_clamp(x2);
          act[2]  <= fp_clamp(x3);
          act[3]  <= fp_clamp(x4);
          cnt     <= '0;
        end
        SUM: begin
          s <= add_res;
          if (cnt == 3'd2) begin
            cnt     <= '0;
            prev_nz <= nz;
            chg     <= 1'b0;
          end else begin
            cnt <= cnt + 3'd1;
          end
        end
        UPD: begin
          // S is not written here, so updating a[i] in place still uses the
          // pre-pass sum for every neuron.
          cnt <= cnt + 3'd1;
          if (!cnt[0]) begin
            t <= add_res;
          end else begin
            act[ui] <= add_neg ? FP_ZERO : add_res;
            if ((add_neg ? FP_ZERO : add_res) != act[ui]) chg <= 1'b1;
          end
        end
        DONE: begin
          out  <= orig[win];
          done <= 1'b1;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_maxnet_top.sv
// Scoreboard bench for maxnet_top: directed vectors with hand-computed winners.
// Latency: checks 2 + 12*N where the iteration count is known.
// Backpressure: n/a.
module tb_maxnet_top;

`ifdef MAXNET_TIMEOUT_EN
  localparam int TB_MAX_ITER = 4;
  localparam bit TB_TMO      = 1'b1;
`else
  localparam int TB_MAX_ITER = 255;
  localparam bit TB_TMO      = 1'b0;
`endif
  localparam int BUDGET = 6000;

  logic        clk   = 1'b0;
  logic        rst   = 1'b1;
  logic        start = 1'b0;
  logic [31:0] x1 = '0, x2 = '0, x3 = '0, x4 = '0;
  logic [31:0] out;
  logic        done;

  maxnet_top #(.EPS_SHIFT(3), .MAX_ITER(TB_MAX_ITER)) dut (
    .clk   (clk),
    .rst   (rst),
    .start (start),
    .x1    (x1),
    .x2    (x2),
    .x3    (x3),
    .x4    (x4),
    .out   (out),
    .done  (done)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc++;

  typedef struct {
    logic [31:0] out;
    int          lat;
    int          sedge;
    string       name;
  } exp_t;

  exp_t  sbq[$];
  exp_t  e;
  int    n_vec = 0;
  int    n_bad = 0;
  logic  chk_idle = 1'b0;
  logic  tmo = 1'b0;
  string tmo_name = "";
  logic  prev_done = 1'b0;

  // Monitor: the only process that compares and steps the counters.
  always @(negedge clk) begin
    if (tmo) begin
      n_vec++;
      n_bad++;
      $display("FAIL %s: done not seen within %0d cycles", tmo_name, BUDGET);
      sbq.delete();
    end
    if (chk_idle) begin
      n_vec++;
      if (out !== 32'h0) begin
        n_bad++;
        $display("FAIL idle_out: got %h want 00000000", out);
      end
      n_vec++;
      if (done !== 1'b0) begin
        n_bad++;
        $display("FAIL idle_done: got %b want 0", done);
      end
    end
    if (!rst) begin
      if (prev_done) begin
        n_vec++;
        if (done !== 1'b0) begin
          n_bad++;
          $display("FAIL done_pulse: done still %b one cycle later, want 0", done);
        end
      end
      if (done === 1'b1) begin
        if (sbq.size() == 0) begin
          n_vec++;
          n_bad++;
          $display("FAIL unexpected_done: out=%h with nothing outstanding", out);
        end else begin
          e = sbq.pop_front();
          n_vec++;
          if (out !== e.out) begin
            n_bad++;
            $display("FAIL %s out: got %h want %h", e.name, out, e.out);
          end
          if (e.lat >= 0) begin
            n_vec++;
            if (cyc - e.sedge != e.lat) begin
              n_bad++;
              $display("FAIL %s latency: got %0d want %0d", e.name, cyc - e.sedge, e.lat);
            end
          end
        end
      end
    end
    prev_done = (done === 1'b1);
  end

  task automatic idle_check();
    @(posedge clk);
    #1 chk_idle = 1'b1;
    @(posedge clk);
    #1 chk_idle = 1'b0;
  endtask

  task automatic run_vec(input logic [31:0] v1, input logic [31:0] v2,
                         input logic [31:0] v3, input logic [31:0] v4,
                         input logic [31:0] want, input int lat, input string nm);
    exp_t x;
    int   waited;
    @(negedge clk);
    x1 = v1; x2 = v2; x3 = v3; x4 = v4;
    start = 1'b1;
    x.out = want; x.lat = lat; x.sedge = cyc + 1; x.name = nm;
    sbq.push_back(x);
    @(negedge clk);
    start = 1'b0;
    waited = 0;
    while (sbq.size() != 0 && waited < BUDGET) begin
      @(negedge clk);
      waited++;
    end
    if (sbq.size() != 0) begin
      tmo_name = nm;
      @(posedge clk);
      #1 tmo = 1'b1;
      @(posedge clk);
      #1 tmo = 1'b0;
    end
    repeat (2) @(negedge clk);
  endtask

  initial begin
    repeat (3) @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    idle_check();

    run_vec(32'h3E4CCCCD, 32'h3ECCCCCD, 32'h3F19999A, 32'h3F4CCCCD, 32'h3F4CCCCD, -1, "ramp_x4");
    run_vec(32'h3F4CCCCD, 32'h3E4CCCCD, 32'h3ECCCCCD, 32'h3F19999A, 32'h3F4CCCCD, -1, "ramp_x1");
    run_vec(32'h3DCCCCCD, 32'h3E800000, 32'h40A66666, 32'h40600000, 32'h40A66666, -1, "big_x3");
    run_vec(32'h40600000, 32'h40A66666, 32'h3DCCCCCD, 32'h3E800000, 32'h40A66666, -1, "big_x2");
    run_vec(32'h3DCCCCCD, 32'h3E800000, 32'h3F733333, 32'h3F59999A, 32'h3F733333,
            TB_TMO ? 50 : 146, "close_x3");
    run_vec(32'h3F000000, 32'h3F000000, 32'h3F000000, 32'h3F000000, 32'h3F000000,
            TB_TMO ? 50 : -1, "equal");
    run_vec(32'hBF800000, 32'h00000000, 32'h00000000, 32'h00000000, 32'hBF800000, 14, "neg_x1");
    run_vec(32'h3F800000, 32'h3F800000, 32'h3F800000, 32'h7FC00000, 32'h7FC00000, 14, "nan_x4");
    run_vec(32'h00400000, 32'h3F800000, 32'hBF800000, 32'h3F000000, 32'h3F800000, -1, "denorm_x1");

    // Abort mid-UPD: nothing is queued, so any done is flagged by the monitor.
    @(negedge clk);
    x1 = 32'h3E4CCCCD; x2 = 32'h3ECCCCCD; x3 = 32'h3F19999A; x4 = 32'h3F4CCCCD;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (4) @(negedge clk);
    rst = 1'b1;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    idle_check();
    repeat (40) @(negedge clk);
    idle_check();

    run_vec(32'h3DCCCCCD, 32'h3E800000, 32'h40A66666, 32'h40600000, 32'h40A66666, -1, "after_rst");

    repeat (5) @(negedge clk);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
